bp_be_accel_writeback: RTL and testbench

BP_BE_ACCEL_WRITEBACK -- requirements
Module: bp_be_accel_writeback

---
 rtl/bp_be_accel_writeback.sv | 189 ++++++++++++++++++
 tb/tb_bp_be_accel_writeback.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_accel_writeback.sv
// Accelerator result writeback: per-channel result FIFOs, round-robin arbitration
// onto one credited uncached write port, with per-channel pointer/done-count CSRs.
module bp_be_accel_writeback #(
  parameter int num_chan_p    = 2,
  parameter int data_width_p  = 128,
  parameter int paddr_width_p = 40,
  parameter int els_p         = 4,
  parameter int credits_p     = 8
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic [num_chan_p-1:0][data_width_p-1:0] res_data_i,
  input  logic [num_chan_p-1:0]                   res_v_i,
  output logic [num_chan_p-1:0]                   res_ready_and_o,
  input  logic                                    csr_w_v_i,
  input  logic [3:0]                              csr_addr_i,
  input  logic [63:0]                             csr_data_i,
  output logic [63:0]                             csr_data_o,
  output logic [paddr_width_p-1:0]                wr_addr_o,
  output logic [data_width_p-1:0]                 wr_data_o,
  output logic                                    wr_v_o,
  input  logic                                    wr_ready_and_i,
  input  logic                                    ack_v_i,
  output logic                                    busy_o,
  output logic                                    error_o
);
  localparam int chan_w_lp = (num_chan_p > 1) ? $clog2(num_chan_p) : 1;
  localparam int ptr_w_lp  = $clog2(els_p);
  localparam int cnt_w_lp  = $clog2(els_p + 1);
  localparam int cred_w_lp = $clog2(credits_p + 1);
  localparam logic [paddr_width_p-1:0] stride_lp = paddr_width_p'(data_width_p / 8);

  typedef enum logic {e_ready, e_send} state_e;

  state_e                   state_q, state_d;
  logic [chan_w_lp-1:0]     grant_q, grant_d;
  // rr_q holds the first channel to try (last_grant+1), so clearing it favours channel 0
  logic [chan_w_lp-1:0]     rr_q, rr_d;
  logic [paddr_width_p-1:0] addr_q, addr_d;
  logic [data_width_p-1:0]  data_q, data_d;
  logic [cred_w_lp-1:0]     credits_q, credits_d;
  logic                     error_q, error_d;

  logic [paddr_width_p-1:0] ptr_q  [num_chan_p];
  logic [paddr_width_p-1:0] ptr_d  [num_chan_p];
  logic [15:0]              done_q [num_chan_p];
  logic [15:0]              done_d [num_chan_p];
  logic [ptr_w_lp-1:0]      wptr_q [num_chan_p];
  logic [ptr_w_lp-1:0]      wptr_d [num_chan_p];
  logic [ptr_w_lp-1:0]      rptr_q [num_chan_p];
  logic [ptr_w_lp-1:0]      rptr_d [num_chan_p];
  logic [cnt_w_lp-1:0]      fcnt_q [num_chan_p];
  logic [cnt_w_lp-1:0]      fcnt_d [num_chan_p];
  logic [data_width_p-1:0]  mem_q  [num_chan_p][els_p];
  logic [data_width_p-1:0]  mem_d  [num_chan_p][els_p];

  logic                 found, issue, enq, deq;
  logic [chan_w_lp-1:0] pick;
  int                   idx;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    credits_d = credits_q;
    error_d   = error_q;
    ptr_d     = ptr_q;
    done_d    = done_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    fcnt_d    = fcnt_q;
    mem_d     = mem_q;
    found     = 1'b0;
    pick      = '0;
    idx       = 0;
    enq       = 1'b0;
    deq       = 1'b0;
    issue     = (state_q == e_send) && wr_ready_and_i;

    if (state_q == e_ready && credits_q < cred_w_lp'(credits_p)) begin
      for (int i = 0; i < num_chan_p; i++) begin
        idx = (int'(rr_q) + i) % num_chan_p;
        if (!found && fcnt_q[idx] != '0) begin
          found = 1'b1;
          pick  = chan_w_lp'(idx);
        end
      end
    end

    for (int c = 0; c < num_chan_p; c++) begin
      enq = res_v_i[c] && (fcnt_q[c] != cnt_w_lp'(els_p));
      deq = found && (pick == chan_w_lp'(c));
      if (enq) begin
        mem_d[c][wptr_q[c]] = res_data_i[c];
        wptr_d[c] = (wptr_q[c] == ptr_w_lp'(els_p - 1)) ? '0 : wptr_q[c] + 1'b1;
      end
      if (deq) begin
        addr_d    = ptr_q[c];
        data_d    = mem_q[c][rptr_q[c]];
        grant_d   = chan_w_lp'(c);
        rr_d      = (c == num_chan_p - 1) ? '0 : chan_w_lp'(c + 1);
        rptr_d[c] = (rptr_q[c] == ptr_w_lp'(els_p - 1)) ? '0 : rptr_q[c] + 1'b1;
      end
      fcnt_d[c] = fcnt_q[c] + cnt_w_lp'(enq) - cnt_w_lp'(deq);

      if (issue && grant_q == chan_w_lp'(c)) begin
        ptr_d[c] = ptr_q[c] + stride_lp;
        if (done_q[c] != 16'hFFFF) done_d[c] = done_q[c] + 16'd1;
      end
      // A CSR write lands after the post-write increment, so software always wins
      if (csr_w_v_i && csr_addr_i == 4'(c)) begin
        ptr_d[c]  = csr_data_i[paddr_width_p-1:0];
        done_d[c] = '0;
      end
    end

    if (found) state_d = e_send;
    if (issue) state_d = e_ready;

    case ({issue, ack_v_i})
      2'b10: credits_d = credits_q + cred_w_lp'(1);
      2'b01: begin
        if (credits_q == '0) error_d = 1'b1;
        else                 credits_d = credits_q - cred_w_lp'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= e_ready;
      grant_q   <= '0;
      rr_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      credits_q <= '0;
      error_q   <= 1'b0;
      for (int c = 0; c < num_chan_p; c++) begin
        ptr_q[c]  <= '0;
        done_q[c] <= '0;
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        fcnt_q[c] <= '0;
      end
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      credits_q <= credits_d;
      error_q   <= error_d;
      ptr_q     <= ptr_d;
      done_q    <= done_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      fcnt_q    <= fcnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_comb begin
    csr_data_o = '0;
    busy_o     = (state_q == e_send) || (credits_q != '0);
    for (int c = 0; c < num_chan_p; c++) begin
      if (csr_addr_i == 4'(c))     csr_data_o[paddr_width_p-1:0] = ptr_q[c];
      if (csr_addr_i == 4'(8 + c)) csr_data_o[15:0] = done_q[c];
      res_ready_and_o[c] = (fcnt_q[c] != cnt_w_lp'(els_p));
      if (fcnt_q[c] != '0) busy_o = 1'b1;
    end
  end

  assign wr_addr_o = addr_q;
  assign wr_data_o = data_q;
  assign wr_v_o    = (state_q == e_send);
  assign error_o   = error_q;

  if (paddr_width_p < 64) begin : g_unused
    logic unused_csr_hi;
    assign unused_csr_hi = ^csr_data_i[63:paddr_width_p];
  end

endmodule

// File: tb/tb_bp_be_accel_writeback.sv
// Scoreboard bench for bp_be_accel_writeback: per-channel expected queues, a
// negedge write monitor that routes each write by the model's pointer, and directed scenarios.
module tb_bp_be_accel_writeback;
  localparam int NCH = 2, DW = 128, AW = 40, ELS = 4, CRED = 2;

  logic                   clk = 1'b0;
  logic                   reset_i = 1'b1;
  logic [NCH-1:0][DW-1:0] res_data;
  logic [NCH-1:0]         res_v, res_ready;
  logic                   csr_w_v;
  logic [3:0]             csr_addr;
  logic [63:0]            csr_wdata, csr_rdata;
  logic [AW-1:0]          wr_addr;
  logic [DW-1:0]          wr_data;
  logic                   wr_v, wr_ready, ack_v, busy, error;

  bp_be_accel_writeback #(
    .num_chan_p(NCH), .data_width_p(DW), .paddr_width_p(AW), .els_p(ELS), .credits_p(CRED)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .res_data_i(res_data), .res_v_i(res_v), .res_ready_and_o(res_ready),
    .csr_w_v_i(csr_w_v), .csr_addr_i(csr_addr), .csr_data_i(csr_wdata), .csr_data_o(csr_rdata),
    .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_v_o(wr_v), .wr_ready_and_i(wr_ready),
    .ack_v_i(ack_v), .busy_o(busy), .error_o(error)
  );

  always #5 clk = ~clk;

  int            n_tests = 0, n_fail = 0;
  logic [DW-1:0] exp_q [NCH][$];
  logic [AW-1:0] m_ptr [NCH];
  int            m_cnt [NCH];
  int            grant_log[$];
  int            outst = 0, n_writes = 0;
  logic [AW-1:0] last_addr;
  bit            ack_auto = 1'b0, ack_force = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: each accepted write is attributed to the channel whose modelled pointer it hits.
  always @(negedge clk) begin
    int ch;
    if (!reset_i) begin
      if (wr_v && wr_ready) begin
        ch = -1;
        for (int c = 0; c < NCH; c++)
          if (ch < 0 && exp_q[c].size() > 0 && m_ptr[c] == wr_addr) ch = c;
        n_writes++;
        last_addr = wr_addr;
        if (ch < 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL wr_route: addr %h matches no channel with pending results", wr_addr);
        end else begin
          check("wr_data", wr_data, exp_q[ch].pop_front());
          m_ptr[ch] = m_ptr[ch] + AW'(DW / 8);
          if (m_cnt[ch] < 'hFFFF) m_cnt[ch]++;
          grant_log.push_back(ch);
          outst++;
        end
      end
      if (ack_v && outst > 0) outst--;
    end
  end

  initial begin
    ack_v = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      ack_v = ack_force || (ack_auto && outst > 0 && $urandom_range(1, 0) == 1);
    end
  end

  task automatic clear_model();
    for (int c = 0; c < NCH; c++) begin
      exp_q[c].delete();
      m_ptr[c] = '0;
      m_cnt[c] = 0;
    end
    grant_log.delete();
    outst = 0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; res_v = '0; csr_w_v = 1'b0; ack_force = 1'b0; ack_auto = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
  endtask

  task automatic cycle_push(input logic [NCH-1:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    res_v = v;
    res_data[0] = d0;
    res_data[1] = d1;
    @(negedge clk);
    for (int c = 0; c < NCH; c++)
      if (v[c] && res_ready[c]) exp_q[c].push_back(res_data[c]);
    @(posedge clk);
    #1;
    res_v = '0;
  endtask

  task automatic csr_write(input logic [3:0] a, input logic [63:0] d);
    csr_w_v = 1'b1; csr_addr = a; csr_wdata = d;
    @(posedge clk);
    #1;
    csr_w_v = 1'b0;
    if (a < NCH) begin
      m_ptr[a] = d[AW-1:0];
      m_cnt[a] = 0;
    end
  endtask

  task automatic csr_check(input logic [3:0] a, input logic [63:0] e, input string name);
    csr_addr = a;
    @(negedge clk);
    check(name, DW'(csr_rdata), DW'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_writes(input int target, input string name);
    int k = 0;
    while (n_writes < target && k < 200) begin
      @(posedge clk); #1; k++;
    end
    n_tests++;
    if (n_writes < target) begin
      n_fail++;
      $display("FAIL %s: timeout with %0d writes, required %0d", name, n_writes, target);
    end
  endtask

  task automatic wait_wv(input string name);
    int k = 0;
    while (!wr_v && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check(name, DW'(wr_v), 1);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while ((exp_q[0].size() + exp_q[1].size() != 0 || outst != 0) && k < 3000) begin
      @(posedge clk); #1; k++;
    end
    n_tests++;
    if (exp_q[0].size() + exp_q[1].size() != 0 || outst != 0) begin
      n_fail++;
      $display("FAIL %s: timeout, pending %0d results and %0d acks, required 0",
               name, exp_q[0].size() + exp_q[1].size(), outst);
    end
  endtask

  initial begin
    int            base;
    logic [DW-1:0] d0;
    res_v = '0; res_data = '0; csr_w_v = 1'b0; csr_addr = '0; csr_wdata = '0; wr_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // reset state
    check("rst_wr_v", DW'(wr_v), 0);
    check("rst_busy", DW'(busy), 0);
    check("rst_error", DW'(error), 0);
    check("rst_ready", DW'(res_ready), 3);

    // single result latency, address stride and done count
    csr_write(0, 64'h1000);
    csr_write(1, 64'h8000);
    csr_check(0, 64'h1000, "csr_ptr0");
    csr_check(5, 64'h0, "csr_unused");
    ack_auto = 1'b1; wr_ready = 1'b1; base = n_writes;
    cycle_push(2'b01, {4{32'hA5A5A5A5}}, '0);
    check("lat_t1_wr_v", DW'(wr_v), 0);
    @(posedge clk);
    #1;
    check("lat_t2_wr_v", DW'(wr_v), 1);
    check("lat_addr", DW'(wr_addr), 'h1000);
    check("lat_data", wr_data, {4{32'hA5A5A5A5}});
    cycle_push(2'b01, rnd(), '0);
    wait_writes(base + 2, "two_writes");
    check("second_addr", DW'(last_addr), 'h1010);
    csr_check(8, 64'd2, "cnt0_two");
    csr_check(0, 64'h1020, "ptr0_after_two");

    // CSR write in the same cycle as the pointer increment
    wr_ready = 1'b0;
    cycle_push(2'b01, rnd(), '0);
    wait_wv("sc_wv");
    wr_ready = 1'b1;
    csr_write(0, 64'h3000);
    csr_check(0, 64'h3000, "sc_ptr0");
    csr_check(8, 64'd0, "sc_cnt0");
    wait_drain("drain_a");

    // round-robin alternation
    do_reset();
    csr_write(0, 64'h1000);
    csr_write(1, 64'h8000);
    ack_auto = 1'b1; wr_ready = 1'b1; base = n_writes;
    repeat (3) cycle_push(2'b11, rnd(), rnd());
    wait_writes(base + 6, "rr_writes");
    check("rr_len", DW'(grant_log.size()), 6);
    for (int i = 0; i < 6; i++) check($sformatf("rr_order_%0d", i), DW'(grant_log[i]), DW'(i % 2));
    wait_drain("drain_b");

    // credit limit
    do_reset();
    csr_write(0, 64'h1000);
    wr_ready = 1'b1; base = n_writes;
    repeat (3) cycle_push(2'b01, rnd(), '0);
    wait_writes(base + 2, "cred_two");
    repeat (6) begin @(posedge clk); #1; end
    check("cred_held_writes", DW'(n_writes - base), 2);
    check("cred_held_wv", DW'(wr_v), 0);
    check("cred_busy", DW'(busy), 1);
    ack_force = 1'b1;
    @(posedge clk);
    #1;
    ack_force = 1'b0;
    wait_writes(base + 3, "cred_release");
    ack_force = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ack_force = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("cred_idle_busy", DW'(busy), 0);
    check("cred_error", DW'(error), 0);
    csr_check(8, 64'd3, "cred_cnt0");

    // stall holds address/data while FIFO fills
    do_reset();
    csr_write(0, 64'h1000);
    ack_auto = 1'b1; wr_ready = 1'b0;
    d0 = rnd();
    cycle_push(2'b01, d0, '0);
    wait_wv("stall_wv");
    for (int i = 0; i < 5; i++) begin
      cycle_push(2'b01, rnd(), '0);
      check("stall_wv_held", DW'(wr_v), 1);
      check("stall_addr", DW'(wr_addr), 'h1000);
      check("stall_data", wr_data, d0);
    end
    check("full_ready0", DW'(res_ready[0]), 0);
    check("full_ready1", DW'(res_ready[1]), 1);
    check("full_depth", DW'(exp_q[0].size()), ELS + 1);
    wr_ready = 1'b1;
    wait_drain("drain_d");
    check("drained_busy", DW'(busy), 0);

    // spurious ack and pointer wrap
    do_reset();
    ack_force = 1'b1;
    @(posedge clk);
    #1;
    ack_force = 1'b0;
    check("err_set", DW'(error), 1);
    check("err_credits_zero", DW'(busy), 0);
    csr_write(0, 64'h00FF_FFFF_FFF0);
    wr_ready = 1'b1; ack_auto = 1'b1; base = n_writes;
    cycle_push(2'b01, rnd(), '0);
    wait_writes(base + 1, "wrap_write");
    csr_check(0, 64'h0, "wrap_ptr0");
    csr_check(8, 64'd1, "wrap_cnt0");
    wait_drain("drain_e");
    check("err_sticky", DW'(error), 1);

    // reset during e_send
    do_reset();
    check("err_cleared", DW'(error), 0);
    csr_write(0, 64'h5000);
    csr_write(1, 64'h6000);
    wr_ready = 1'b0;
    cycle_push(2'b11, rnd(), rnd());
    wait_wv("rst_send_wv");
    reset_i = 1'b1;
    clear_model();
    @(posedge clk);
    #1;
    check("rst_send_wv_off", DW'(wr_v), 0);
    check("rst_send_ready", DW'(res_ready), 3);
    reset_i = 1'b0;
    for (int i = 0; i < 16; i++) csr_check(4'(i), 64'h0, $sformatf("rst_csr_%0d", i));
    check("rst_send_busy", DW'(busy), 0);

    // randomized traffic
    do_reset();
    csr_write(0, 64'h10_0000_0000);
    csr_write(1, 64'h20_0000_0000);
    ack_auto = 1'b1;
    for (int i = 0; i < 300; i++) begin
      wr_ready = ($urandom_range(3, 0) != 0);
      cycle_push(NCH'($urandom_range(3, 0)), rnd(), rnd());
    end
    wr_ready = 1'b1;
    wait_drain("drain_rand");
    csr_check(0, 64'(m_ptr[0]), "rand_ptr0");
    csr_check(1, 64'(m_ptr[1]), "rand_ptr1");
    csr_check(8, 64'(m_cnt[0]), "rand_cnt0");
    csr_check(9, 64'(m_cnt[1]), "rand_cnt1");
    check("rand_busy", DW'(busy), 0);
    check("rand_error", DW'(error), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
